// File: rtl/zimbo_mem_responder_if.sv
// rtl/zimbo_mem_responder_if.sv - request/response bundle between the Zimbo core and its memory responder
interface zimbo_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/zimbo_mem_responder.sv
// rtl/zimbo_mem_responder.sv - word RAM responder with programmable wait states and one-cycle response pulse
module zimbo_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    zimbo_mem_responder_if.slave  bus
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    localparam logic [3:0]  WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q;
    logic [15:0]     wdata_q;
    logic            write_q;
    logic            req_err_q;
    logic [15:0]     rdata_q;
    logic            err_q;
    logic            ready;
    logic            busy;
    logic            valid;
    logic            accept;

    logic [15:0]     mem [DEPTH];

    logic            bus_err;
    logic [AW-1:0]   src_idx;
    logic            src_err;
    logic            src_write;
    logic [15:0]     mem_word;

    assign bus_err = bus.req_addr[0] || ({1'b0, bus.req_addr[15:1]} >= DEPTH_W);
    assign accept  = bus.req_valid && ready;

    // With zero wait states the response is loaded on the acceptance edge,
    // before the latched copy exists, so the source comes straight from the bus.
    assign src_idx   = (state_q == IDLE) ? bus.req_addr[AW:1] : idx_q;
    assign src_err   = (state_q == IDLE) ? bus_err            : req_err_q;
    assign src_write = (state_q == IDLE) ? bus.req_write      : write_q;
    assign mem_word  = src_err ? 16'h0000 : mem[src_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        busy    = 1'b0;
        valid   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = !rst;
                if (bus.req_valid && !rst) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                busy    = 1'b1;
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wdata_q   <= 16'h0000;
            write_q   <= 1'b0;
            req_err_q <= 1'b0;
            rdata_q   <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q     <= bus.req_addr[AW:1];
                wdata_q   <= bus.req_wdata;
                write_q   <= bus.req_write;
                req_err_q <= bus_err;
            end
            if (state_d == RESP) begin
                rdata_q <= (src_err || src_write) ? 16'h0000 : mem_word;
                err_q   <= src_err;
            end else begin
                rdata_q <= 16'h0000;
                err_q   <= 1'b0;
            end
        end
    end

    // RAM is deliberately outside reset; a reset during RESP drops the store.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && write_q && !req_err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.req_ready = ready;
    assign bus.busy      = busy;
    assign bus.rsp_valid = valid;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_zimbo_mem_responder.sv
// tb/tb_zimbo_mem_responder.sv - lockstep check of WAIT_STATES 0/1/3 responders against a word-array model
module tb_zimbo_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    zimbo_mem_responder_if if0 ();
    zimbo_mem_responder_if if1 ();
    zimbo_mem_responder_if if3 ();

    assign if0.req_valid = req_valid;  assign if0.req_write = req_write;
    assign if0.req_addr  = req_addr;   assign if0.req_wdata = req_wdata;
    assign if1.req_valid = req_valid;  assign if1.req_write = req_write;
    assign if1.req_addr  = req_addr;   assign if1.req_wdata = req_wdata;
    assign if3.req_valid = req_valid;  assign if3.req_write = req_write;
    assign if3.req_addr  = req_addr;   assign if3.req_wdata = req_wdata;

    zimbo_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    zimbo_mem_responder #(.DEPTH(1024), .WAIT_STATES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    zimbo_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    logic        rv  [3];
    logic [15:0] rd  [3];
    logic        er  [3];
    logic        rdy [3];
    logic        bsy [3];

    assign rv[0]  = if0.rsp_valid;  assign rv[1]  = if1.rsp_valid;  assign rv[2]  = if3.rsp_valid;
    assign rd[0]  = if0.rsp_rdata;  assign rd[1]  = if1.rsp_rdata;  assign rd[2]  = if3.rsp_rdata;
    assign er[0]  = if0.rsp_err;    assign er[1]  = if1.rsp_err;    assign er[2]  = if3.rsp_err;
    assign rdy[0] = if0.req_ready;  assign rdy[1] = if1.req_ready;  assign rdy[2] = if3.req_ready;
    assign bsy[0] = if0.busy;       assign bsy[1] = if1.busy;       assign bsy[2] = if3.busy;

    int          ws [3] = '{0, 1, 3};
    logic [15:0] mm [3][1024];
    bit          kn [3][1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request presented to all three builds at once; each must answer
    // after its own latency with the value the word-array model predicts.
    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d, input string tag);
        logic err;
        int   idx;
        int   got [3];
        err = a[0] || (a >= 16'h0800);
        idx = int'(a >> 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int k = 0; k < 3; k++) chk({tag, "_ready"}, 32'(rdy[k]), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        got = '{-1, -1, -1};
        for (int c = 1; c <= 6; c++) begin
            for (int k = 0; k < 3; k++) begin
                chk({tag, "_busy"}, 32'(bsy[k]), 32'(c <= ws[k] + 1));
                chk({tag, "_ready_post"}, 32'(rdy[k]), 32'(c > ws[k] + 1));
                if (rv[k]) begin
                    if (got[k] != -1) chk({tag, "_extra_pulse"}, 32'(c), 32'(got[k]));
                    got[k] = c;
                    chk({tag, "_err"}, 32'(er[k]), 32'(err));
                    if (err || w) chk({tag, "_rdata0"}, 32'(rd[k]), 32'h0);
                    else if (kn[k][idx]) chk({tag, "_rdata"}, 32'(rd[k]), 32'(mm[k][idx]));
                end else begin
                    chk({tag, "_idle_rdata"}, 32'(rd[k]), 32'h0);
                    chk({tag, "_idle_err"}, 32'(er[k]), 32'h0);
                end
            end
            if (c < 6) @(negedge clk);
        end
        for (int k = 0; k < 3; k++) chk({tag, "_latency"}, 32'(got[k]), 32'(ws[k] + 1));
        if (w && !err) begin
            for (int k = 0; k < 3; k++) begin
                mm[k][idx] = d;
                kn[k][idx] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    int q    [3][$];
    int last [3];
    int nacc [3];
    int nrsp [3];

    initial begin
        int          r;
        logic [15:0] a;
        logic [15:0] d;
        logic        w;

        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'hDEAD;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("rst_ready", 32'(rdy[k]), 32'd0);
                chk("rst_rsp_valid", 32'(rv[k]), 32'd0);
            end
        end
        req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_ready", 32'(rdy[k]), 32'd1);
            chk("post_rst_busy", 32'(bsy[k]), 32'd0);
            chk("post_rst_rsp_valid", 32'(rv[k]), 32'd0);
            chk("post_rst_rdata", 32'(rd[k]), 32'd0);
            chk("post_rst_err", 32'(er[k]), 32'd0);
        end

        txn(1'b1, 16'h0010, 16'hBEEF, "store_beef");
        txn(1'b0, 16'h0010, 16'h0000, "load_beef");
        txn(1'b1, 16'h0011, 16'h1234, "misaligned_store");
        txn(1'b0, 16'h0010, 16'h0000, "load_beef_again");
        txn(1'b0, 16'h0800, 16'h0000, "load_oor");
        txn(1'b1, 16'h07FE, 16'h5A5A, "store_top");
        txn(1'b0, 16'h07FE, 16'h0000, "load_top");
        txn(1'b1, 16'h0020, 16'h1111, "store_1111");

        // Held req_valid: each build accepts at its own cadence.
        last = '{-1, -1, -1};
        nacc = '{0, 0, 0};
        nrsp = '{0, 0, 0};
        req_write = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0000;
        for (int c = 0; c < 30; c++) begin
            req_valid = (c < 24);
            for (int k = 0; k < 3; k++) begin
                if (rv[k]) begin
                    nrsp[k]++;
                    if (q[k].size() == 0) begin
                        chk("b2b_orphan_rsp", 32'(q[k].size()), 32'd1);
                    end else begin
                        chk("b2b_latency", 32'(c - q[k].pop_front()), 32'(ws[k] + 1));
                        chk("b2b_rdata", 32'(rd[k]), 32'hBEEF);
                        chk("b2b_err", 32'(er[k]), 32'd0);
                    end
                end
                if (rdy[k] && req_valid) begin
                    if (last[k] >= 0) chk("b2b_interval", 32'(c - last[k]), 32'(ws[k] + 2));
                    last[k] = c;
                    q[k].push_back(c);
                    nacc[k]++;
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            chk("b2b_accepts", 32'(nacc[k]), 32'((24 + ws[k] + 1) / (ws[k] + 2)));
            chk("b2b_rsp_count", 32'(nrsp[k]), 32'(nacc[k]));
            chk("b2b_pending", 32'(q[k].size()), 32'd0);
        end

        // Store AAAA, reset during the 3-wait build's second WAIT cycle.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'hAAAA;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rv[2]), 32'd0);
        chk("abort_busy", 32'(bsy[2]), 32'd0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("abort_idle_ready", 32'(rdy[k]), 32'd1);
                chk("abort_idle_busy", 32'(bsy[k]), 32'd0);
                chk("abort_no_rsp", 32'(rv[k]), 32'd0);
            end
        end
        // 0-wait build committed before the reset; the 1-wait build was in RESP.
        mm[0][16] = 16'hAAAA;
        txn(1'b0, 16'h0020, 16'h0000, "load_after_abort");

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 16'(($urandom_range(0, 31) << 1) | 1);
            else if (r == 1) a = 16'($urandom_range(16'h0800, 16'hFFFF));
            else if (r < 6)  a = 16'($urandom_range(0, 31) << 1);
            else             a = 16'($urandom_range(1000, 1023) << 1);
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            txn(w, a, d, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
